// File: rtl/sample_narrow_pkg.sv
// Shared constants for sample_narrow_axil: register map, CTRL field layout,
// narrowing modes, reset values and the AXI handshake state encodings.
package sample_narrow_pkg;

   localparam logic [3:0] ADDR_CTRL = 4'h0;
   localparam logic [3:0] ADDR_MUTE = 4'h4;
   localparam logic [3:0] ADDR_CLIP = 4'h8;
   localparam logic [3:0] ADDR_ID   = 4'hC;

   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_MODE_LSB  = 1;
   localparam int CTRL_SHIFT_LSB = 4;

   localparam logic [31:0] CTRL_RESET = 32'h0000_0003;
   localparam logic [7:0]  ID_VERSION = 8'h01;

   // Mode 2'b11 is not listed: the datapath treats it exactly like ROUND_SAT.
   typedef enum logic [1:0] {
      TRUNC_SAT  = 2'b00,
      ROUND_SAT  = 2'b01,
      TRUNC_WRAP = 2'b10
   } mode_e;

   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

   function automatic logic [31:0] make_id(input int in_w, input int out_w, input int num_ch);
      return {8'(in_w), 8'(out_w), 8'(num_ch), ID_VERSION};
   endfunction

endpackage

// File: rtl/sample_narrow_axil_regs.sv
// AXI4-Lite slave handshake and register file for sample_narrow_axil.
// Clip counter only exists when SAMPLE_NARROW_CLIP_CNT_EN is defined.
module sample_narrow_axil_regs
   import sample_narrow_pkg::*;
#(
   parameter int IN_W   = 31,
   parameter int OUT_W  = 24,
   parameter int NUM_CH = 4
) (
   input  logic              ACLK,
   input  logic              ARESETN,
   input  logic [3:0]        s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [3:0]        s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready,
   input  logic              i_clipEvt,
   output logic              o_en,
   output logic [1:0]        o_mode,
   output logic [3:0]        o_shift,
   output logic [NUM_CH-1:0] o_mute
);

   localparam logic [31:0] ID_WORD = make_id(IN_W, OUT_W, NUM_CH);

   wr_state_e         r_wState, w_wNext;
   rd_state_e         r_rState, w_rNext;
   logic              w_wrFire, w_rdFire;
   logic [3:0]        w_wAddr, w_rAddr;
   logic              r_en;
   logic [1:0]        r_mode;
   logic [3:0]        r_shift;
   logic [NUM_CH-1:0] r_mute;
   logic [31:0]       r_rdata, w_rdMux, w_ctrlWord, w_clipCnt;
   logic              w_unused;

   assign w_wAddr = {s_axi_awaddr[3:2], 2'b00};
   assign w_rAddr = {s_axi_araddr[3:2], 2'b00};

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_wState <= W_IDLE;
         r_rState <= R_IDLE;
      end else begin
         r_wState <= w_wNext;
         r_rState <= w_rNext;
      end
   end

   // Ready strobes come from the state register so they are low in reset
   // and can only pulse once per transaction.
   always_comb begin
      w_wNext       = r_wState;
      w_wrFire      = 1'b0;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      case (r_wState)
         W_IDLE: if (s_axi_awvalid && s_axi_wvalid) w_wNext = W_ACK;
         W_ACK: begin
            s_axi_awready = 1'b1;
            s_axi_wready  = 1'b1;
            w_wrFire      = 1'b1;
            w_wNext       = W_RESP;
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_wNext = W_IDLE;
         end
         default: w_wNext = W_IDLE;
      endcase
   end

   always_comb begin
      w_rNext       = r_rState;
      w_rdFire      = 1'b0;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      case (r_rState)
         R_IDLE: if (s_axi_arvalid) w_rNext = R_ACK;
         R_ACK: begin
            s_axi_arready = 1'b1;
            w_rdFire      = 1'b1;
            w_rNext       = R_DATA;
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) w_rNext = R_IDLE;
         end
         default: w_rNext = R_IDLE;
      endcase
   end

   assign s_axi_bresp = 2'b00;
   assign s_axi_rresp = 2'b00;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_en    <= CTRL_RESET[CTRL_EN_BIT];
         r_mode  <= CTRL_RESET[CTRL_MODE_LSB +: 2];
         r_shift <= CTRL_RESET[CTRL_SHIFT_LSB +: 4];
         r_mute  <= '0;
      end else if (w_wrFire) begin
         if (w_wAddr == ADDR_CTRL && s_axi_wstrb[0]) begin
            r_en    <= s_axi_wdata[CTRL_EN_BIT];
            r_mode  <= s_axi_wdata[CTRL_MODE_LSB +: 2];
            r_shift <= s_axi_wdata[CTRL_SHIFT_LSB +: 4];
         end
         if (w_wAddr == ADDR_MUTE) begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (s_axi_wstrb[i/8]) r_mute[i] <= s_axi_wdata[i];
            end
         end
      end
   end

`ifdef SAMPLE_NARROW_CLIP_CNT_EN
   logic [31:0] r_clipCnt;

   // A clear write on the same edge as a clip event leaves the count at zero.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_clipCnt <= '0;
      end else if (w_wrFire && w_wAddr == ADDR_CLIP) begin
         r_clipCnt <= '0;
      end else if (i_clipEvt && r_clipCnt != '1) begin
         r_clipCnt <= r_clipCnt + 32'd1;
      end
   end

   assign w_clipCnt = r_clipCnt;
`else
   assign w_clipCnt = '0;
`endif

   always_comb begin
      w_ctrlWord                          = '0;
      w_ctrlWord[CTRL_EN_BIT]             = r_en;
      w_ctrlWord[CTRL_MODE_LSB +: 2]      = r_mode;
      w_ctrlWord[CTRL_SHIFT_LSB +: 4]     = r_shift;
      w_rdMux                             = '0;
      case (w_rAddr)
         ADDR_CTRL: w_rdMux = w_ctrlWord;
         ADDR_MUTE: w_rdMux[NUM_CH-1:0] = r_mute;
         ADDR_CLIP: w_rdMux = w_clipCnt;
         ADDR_ID:   w_rdMux = ID_WORD;
         default:   w_rdMux = '0;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN)      r_rdata <= '0;
      else if (w_rdFire) r_rdata <= w_rdMux;
   end

   assign s_axi_rdata = r_rdata;
   assign o_en        = r_en;
   assign o_mode      = r_mode;
   assign o_shift     = r_shift;
   assign o_mute      = r_mute;
   assign w_unused    = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata, s_axi_wstrb, i_clipEvt};

endmodule

// File: rtl/sample_narrow_axil.sv
// Multichannel signed sample narrowing (IN_W -> OUT_W) with shift, round,
// saturate/wrap and mute; 2-stage datapath. Optional macro: SAMPLE_NARROW_CLIP_CNT_EN.
module sample_narrow_axil
   import sample_narrow_pkg::*;
#(
   parameter int IN_W   = 31,
   parameter int OUT_W  = 24,
   parameter int NUM_CH = 4
) (
   input  logic                        ACLK,
   input  logic                        ARESETN,
   input  logic [3:0]                  s_axi_awaddr,
   input  logic [2:0]                  s_axi_awprot,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [31:0]                 s_axi_wdata,
   input  logic [3:0]                  s_axi_wstrb,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [3:0]                  s_axi_araddr,
   input  logic [2:0]                  s_axi_arprot,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [31:0]                 s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic signed [IN_W-1:0]      s_data,
   input  logic [$clog2(NUM_CH)-1:0]   s_ch,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic signed [OUT_W-1:0]     m_data,
   output logic [$clog2(NUM_CH)-1:0]   m_ch
);

   localparam int D   = IN_W - OUT_W;
   localparam int XW  = IN_W + 16;
   localparam int CHW = $clog2(NUM_CH);
   localparam logic signed [XW-1:0] RND  = XW'(1) <<< (D - 1);
   localparam logic signed [XW-1:0] SMAX = (XW'(1) <<< (OUT_W - 1)) - XW'(1);
   localparam logic signed [XW-1:0] SMIN = ~SMAX;

   logic                     w_en;
   logic [1:0]               w_mode;
   logic [3:0]               w_shift;
   logic [NUM_CH-1:0]        w_mute;
   logic                     w_clipEvt, w_clip;
   logic                     w_adv1, w_adv2, w_acc;
   logic signed [XW-1:0]     w_xs, w_x, w_xr, w_y;
   logic signed [OUT_W-1:0]  w_sat;
   logic                     r_alive, r_v1, r_v2, r_mute1;
   logic [1:0]               r_mode1;
   logic signed [XW-1:0]     r_y1;
   logic [CHW-1:0]           r_ch1, r_ch2;
   logic signed [OUT_W-1:0]  r_data2;
   logic                     w_unused;

   sample_narrow_axil_regs #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)) u_regs (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .i_clipEvt     (w_clipEvt),
      .o_en          (w_en),
      .o_mode        (w_mode),
      .o_shift       (w_shift),
      .o_mute        (w_mute)
   );

   assign w_adv2  = !r_v2 || m_ready;
   assign w_adv1  = !r_v1 || w_adv2;
   assign s_ready = r_alive && w_adv1;
   assign w_acc   = s_valid && s_ready;

   // Stage 1 math: mode[0] selects rounding, so mode 2'b11 behaves as ROUND_SAT.
   always_comb begin
      w_xs = XW'(s_data);
      w_x  = w_xs <<< w_shift;
      w_xr = w_mode[0] ? (w_x + RND) : w_x;
      w_y  = w_xr >>> D;
   end

   always_comb begin
      w_sat  = r_y1[OUT_W-1:0];
      w_clip = 1'b0;
      if (r_mute1) begin
         w_sat = '0;
      end else if (r_mode1 != TRUNC_WRAP) begin
         if (r_y1 > SMAX) begin
            w_sat  = SMAX[OUT_W-1:0];
            w_clip = 1'b1;
         end else if (r_y1 < SMIN) begin
            w_sat  = SMIN[OUT_W-1:0];
            w_clip = 1'b1;
         end
      end
   end

   assign w_clipEvt = r_v1 && w_adv2 && w_clip;

   // CTRL/MUTE are captured with the sample so mid-stream writes never split a sample.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_alive <= 1'b0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_y1    <= '0;
         r_mode1 <= 2'b00;
         r_mute1 <= 1'b0;
         r_ch1   <= '0;
         r_data2 <= '0;
         r_ch2   <= '0;
      end else begin
         r_alive <= 1'b1;
         if (w_adv1) begin
            r_v1 <= w_acc && w_en;
            if (w_acc && w_en) begin
               r_y1    <= w_y;
               r_mode1 <= w_mode;
               r_mute1 <= w_mute[s_ch];
               r_ch1   <= s_ch;
            end
         end
         if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
               r_data2 <= w_sat;
               r_ch2   <= r_ch1;
            end
         end
      end
   end

   assign m_valid  = r_v2;
   assign m_data   = r_data2;
   assign m_ch     = r_ch2;
   assign w_unused = ^{s_axi_awprot, s_axi_arprot};

endmodule

// File: tb/tb_sample_narrow_axil.sv
// Directed self-checking bench for sample_narrow_axil (default 31->24, 4 channels).
// Clip-count expectations follow SAMPLE_NARROW_CLIP_CNT_EN.
module tb_sample_narrow_axil;

   localparam int IN_W   = 31;
   localparam int OUT_W  = 24;
   localparam int NUM_CH = 4;
`ifdef SAMPLE_NARROW_CLIP_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic ACLK = 1'b0;
   logic ARESETN = 1'b1;
   logic [3:0]  s_axi_awaddr = '0;
   logic [2:0]  s_axi_awprot = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b0;
   logic [3:0]  s_axi_araddr = '0;
   logic [2:0]  s_axi_arprot = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic signed [IN_W-1:0]  s_data = '0;
   logic [1:0]  s_ch = '0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic signed [OUT_W-1:0] m_data;
   logic [1:0]  m_ch;

   int nCompared = 0;
   int nMismatched = 0;
   logic [31:0] outQ[$];

   sample_narrow_axil #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
      .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
      .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
      .s_axi_rready(s_axi_rready), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_ch(s_ch), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch)
   );

   always #5 ACLK = ~ACLK;

   // Record every output transfer; values at the falling edge are what the next rising edge takes.
   always @(negedge ACLK) begin
      if (m_valid && m_ready) outQ.push_back({6'd0, m_ch, m_data});
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [IN_W-1:0] data, input logic [1:0] ch);
      int n;
      s_data  = data;
      s_ch    = ch;
      s_valid = 1'b1;
      #1;
      n = 0;
      while (!s_ready && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      checkOutput("s_ready_wait", {31'd0, s_ready}, 32'd1);
      @(posedge ACLK); #1;
      s_valid = 1'b0;
   endtask

   task automatic expectOut(input string tag, input logic [1:0] ch, input logic [23:0] data);
      int n;
      logic [31:0] item;
      n = 0;
      while (outQ.size() == 0 && n < 20) begin
         @(posedge ACLK); #1;
         n++;
      end
      checkOutput({tag, "_avail"}, {31'd0, outQ.size() != 0}, 32'd1);
      if (outQ.size() != 0) begin
         item = outQ.pop_front();
         checkOutput({tag, "_data"}, {8'd0, item[23:0]}, {8'd0, data});
         checkOutput({tag, "_ch"}, {30'd0, item[25:24]}, {30'd0, ch});
      end
   endtask

   task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n;
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b1;
      n = 0;
      do begin
         @(posedge ACLK); #1;
         n++;
      end while (!s_axi_awready && n < 20);
      checkOutput("aw_handshake", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
      @(posedge ACLK); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      checkOutput("bvalid", {31'd0, s_axi_bvalid}, 32'd1);
      checkOutput("bresp", {30'd0, s_axi_bresp}, 32'd0);
      @(posedge ACLK); #1;
      s_axi_bready = 1'b0;
   endtask

   task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
      int n;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      s_axi_rready  = 1'b1;
      n = 0;
      do begin
         @(posedge ACLK); #1;
         n++;
      end while (!s_axi_arready && n < 20);
      checkOutput("ar_handshake", {31'd0, s_axi_arready}, 32'd1);
      @(posedge ACLK); #1;
      s_axi_arvalid = 1'b0;
      checkOutput("rvalid", {31'd0, s_axi_rvalid}, 32'd1);
      checkOutput("rresp", {30'd0, s_axi_rresp}, 32'd0);
      data = s_axi_rdata;
      @(posedge ACLK); #1;
      s_axi_rready = 1'b0;
   endtask

   task automatic readCheck(input string tag, input logic [3:0] addr, input logic [31:0] expected);
      logic [31:0] d;
      axiRead(addr, d);
      checkOutput(tag, d, expected);
   endtask

   initial begin
      int  idx;
      int  cyc;
      logic acc;

      // Reset state
      #1 ARESETN = 1'b0;
      @(posedge ACLK); #2;
      checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
      checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
      checkOutput("rst_m_data", {8'd0, m_data}, 32'd0);
      checkOutput("rst_m_ch", {30'd0, m_ch}, 32'd0);
      checkOutput("rst_axi_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
      checkOutput("rst_axi_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
      checkOutput("rst_rdata", s_axi_rdata, 32'd0);
      checkOutput("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      checkOutput("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
      $display("[TB] reset checks done");

      // Register defaults
      readCheck("ctrl_reset", 4'h0, 32'h0000_0003);
      readCheck("mute_reset", 4'h4, 32'h0);
      readCheck("clip_reset", 4'h8, 32'h0);
      readCheck("id", 4'hC, 32'h1F18_0401);

      // Round-saturate defaults
      applyStimulus(31'd64, 2'd0);
      expectOut("rs_64", 2'd0, 24'd1);
      applyStimulus(31'd256, 2'd1);
      expectOut("rs_256", 2'd1, 24'd2);

      // Truncate-saturate
      axiWrite(4'h0, 32'h1, 4'hF);
      applyStimulus(31'd64, 2'd2);
      expectOut("ts_64", 2'd2, 24'd0);

      // Positive clip and exact negative full scale
      axiWrite(4'h0, 32'h3, 4'hF);
      applyStimulus(31'h3FFF_FFFF, 2'd0);
      expectOut("rs_posclip", 2'd0, 24'h7F_FFFF);
      readCheck("clip_after_pos", 4'h8, 32'(CNT_ON * 1));
      applyStimulus(31'h4000_0000, 2'd3);
      expectOut("rs_negfs", 2'd3, 24'h80_0000);
      readCheck("clip_after_negfs", 4'h8, 32'(CNT_ON * 1));

      // Shift by one: wrap then saturate
      axiWrite(4'h0, 32'h15, 4'hF);
      applyStimulus(31'h3FFF_FFFF, 2'd1);
      expectOut("wrap_sh1", 2'd1, 24'hFF_FFFF);
      readCheck("clip_after_wrap", 4'h8, 32'(CNT_ON * 1));
      axiWrite(4'h0, 32'h11, 4'hF);
      applyStimulus(31'h3FFF_FFFF, 2'd1);
      expectOut("ts_sh1", 2'd1, 24'h7F_FFFF);
      readCheck("clip_after_ts_sh1", 4'h8, 32'(CNT_ON * 2));

      // Byte strobes: a zero strobe write leaves CTRL untouched
      axiWrite(4'h0, 32'h3, 4'hF);
      axiWrite(4'h0, 32'h0, 4'b1110);
      readCheck("ctrl_strb", 4'h0, 32'h3);

      // Mute channel 1
      axiWrite(4'h4, 32'h2, 4'hF);
      axiWrite(4'h4, 32'hF, 4'h0);
      readCheck("mute_rd", 4'h4, 32'h2);
      applyStimulus(31'd256, 2'd0);
      applyStimulus(31'd256, 2'd1);
      applyStimulus(31'd256, 2'd2);
      applyStimulus(31'd256, 2'd3);
      expectOut("mute_c0", 2'd0, 24'd2);
      expectOut("mute_c1", 2'd1, 24'd0);
      expectOut("mute_c2", 2'd2, 24'd2);
      expectOut("mute_c3", 2'd3, 24'd2);
      applyStimulus(31'h3FFF_FFFF, 2'd1);
      expectOut("mute_noclip", 2'd1, 24'd0);
      readCheck("clip_after_mute", 4'h8, 32'(CNT_ON * 2));
      axiWrite(4'h4, 32'h0, 4'hF);

      // Disabled: samples accepted and dropped
      axiWrite(4'h0, 32'h2, 4'hF);
      applyStimulus(31'd256, 2'd0);
      repeat (5) @(posedge ACLK);
      #1;
      checkOutput("en0_drop", 32'(outQ.size()), 32'd0);
      checkOutput("en0_s_ready", {31'd0, s_ready}, 32'd1);
      axiWrite(4'h0, 32'h3, 4'hF);

      // Backpressure: m_ready low for the first 5 cycles of an 8-sample burst
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 100) begin
         m_ready = (cyc >= 5);
         s_valid = 1'b1;
         s_data  = 31'(256 * (idx + 1));
         s_ch    = 2'(idx % 4);
         #1;
         if (cyc == 2) checkOutput("bp_s_ready_low", {31'd0, s_ready}, 32'd0);
         if (cyc == 4) checkOutput("bp_hold_data", {7'd0, m_valid, m_data}, {7'd0, 1'b1, 24'd2});
         acc = s_ready;
         @(posedge ACLK); #1;
         if (acc) idx++;
         cyc++;
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         expectOut($sformatf("bp_%0d", k), 2'(k % 4), 24'(2 * (k + 1)));
      end
      repeat (3) @(posedge ACLK);
      #1;
      checkOutput("bp_no_extra", 32'(outQ.size()), 32'd0);

      // Clip event on the same edge as the CLIP_CNT clear write
      s_axi_awaddr  = 4'h8;
      s_axi_wdata   = 32'h0;
      s_axi_wstrb   = 4'hF;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      s_axi_bready  = 1'b1;
      s_valid       = 1'b1;
      s_data        = 31'h3FFF_FFFF;
      s_ch          = 2'd0;
      @(posedge ACLK); #1;
      s_valid = 1'b0;
      checkOutput("coinc_awready", {31'd0, s_axi_awready}, 32'd1);
      @(posedge ACLK); #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      checkOutput("coinc_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
      @(posedge ACLK); #1;
      s_axi_bready = 1'b0;
      expectOut("coinc_out", 2'd0, 24'h7F_FFFF);
      readCheck("coinc_clip_cleared", 4'h8, 32'h0);

      // Reset in the middle of a burst
      axiWrite(4'h0, 32'h15, 4'hF);
      readCheck("ctrl_before_rst", 4'h0, 32'h15);
      s_valid = 1'b1;
      s_ch    = 2'd0;
      for (int k = 0; k < 3; k++) begin
         s_data = 31'(5000 + 1000 * k);
         @(posedge ACLK); #1;
      end
      ARESETN = 1'b0;
      s_valid = 1'b0;
      outQ.delete();
      #1;
      checkOutput("rst_mid_m_valid", {31'd0, m_valid}, 32'd0);
      checkOutput("rst_mid_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge ACLK); #1;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      repeat (5) @(posedge ACLK);
      #1;
      checkOutput("rst_flush_q", 32'(outQ.size()), 32'd0);
      checkOutput("rst_flush_m_valid", {31'd0, m_valid}, 32'd0);
      readCheck("ctrl_after_rst", 4'h0, 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/sample_narrow_axil.md
# sample_narrow_axil

Parametrised, multichannel sample-width narrowing block for the synth output path: converts signed IN_W-bit voice-mix samples to signed OUT_W-bit DAC/I2S samples with selectable truncate/round/saturate/wrap modes, a per-sample gain shift, per-channel mute and a clip counter. It is the configurable successor to the fixed 31-to-24 converter and keeps the AXI4-Lite slave control port so the PS driver can program it at runtime.

## Interface
- IN_W, 31, input sample width (signed); IN_W > OUT_W required
- OUT_W, 24, output sample width (signed)
- NUM_CH, 4, channel count (2..16), time-multiplexed on one stream
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  asynchronous active-low reset
- s_axi_awaddr/awprot/awvalid/awready  AXI4-Lite write address (addr 4 b)
- s_axi_wdata/wstrb/wvalid/wready  write data 32 b, strobe 4 b
- s_axi_bresp/bvalid/bready  write response
- s_axi_araddr/arprot/arvalid/arready  read address (addr 4 b)
- s_axi_rdata/rresp/rvalid/rready  read data 32 b
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid && s_ready
- s_data  in  IN_W  signed input sample
- s_ch  in  $clog2(NUM_CH)  channel index of s_data
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_W  signed narrowed sample
- m_ch  out  $clog2(NUM_CH)  channel index, passed through

## Operation
- Registers (byte offset): 0x0 CTRL RW: bit0 EN, bits2:1 MODE, bits7:4 SHIFT; reset 0x0000_0003. 0x4 MUTE RW [NUM_CH-1:0], reset 0. 0x8 CLIP_CNT RO, any write clears. 0xC ID RO = {IN_W[7:0], OUT_W[7:0], NUM_CH[7:0], 8'h01}.
- wstrb honoured per byte; unmapped bits read 0; bresp/rresp always OKAY (2'b00).
- D = IN_W − OUT_W. Stage 1: x = sign-extend(s_data) <<< SHIFT in IN_W+16 bits; if MODE round, x += 2^(D−1); y = x >>> D.
- Stage 2: MODE 00 truncate-saturate, 01 round-saturate, 11 = 01, 10 truncate-wrap (low OUT_W bits of y). Saturate clamps y to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; each clamp is one clip event.
- Muted channel (MUTE[s_ch]=1): m_data = 0, sample still forwarded, no clip event.
- EN=0: s_ready=1, accepted samples are dropped; samples already in the pipeline drain normally.
- CTRL/MUTE sampled per sample at stage-1 capture; mid-stream changes apply from next accepted sample.
- CLIP_CNT saturates at 0xFFFF_FFFF; clip event coincident with clear write → result 0 (clear wins).

## Timing
- Sample latency 2 cycles (accept at edge N → m_valid at edge N+2) with m_ready held high; full throughput 1 sample/cycle.
- Backpressure: stage advances when next stage empty or advancing; s_ready = !v1 || (!v2 || m_ready). m_data/m_ch stable while m_valid && !m_ready.
- AXI write: awready and wready pulse together for one cycle only when awvalid && wvalid && !bvalid; register updates on that edge; bvalid next cycle, held until bready.
- AXI read: arready pulses one cycle when arvalid && !rvalid; rvalid/rdata next cycle, held until rready.
- Reset values: all ready/valid outputs 0 (s_ready 0 during reset, 1 after), m_data 0, m_ch 0, rdata 0, bresp/rresp 0, registers as above. Reset mid-stream flushes both stages; in-flight AXI transactions are abandoned.

## Configuration
- SAMPLE_NARROW_CLIP_CNT_EN defined: clip counter built, CLIP_CNT as specified.
- Undefined: no counter logic; CLIP_CNT reads 0, writes ignored; saturation unaffected.

## Structure
- Package sample_narrow_pkg: register offsets, CTRL field positions, mode enum (TRUNC_SAT, ROUND_SAT, TRUNC_WRAP), CTRL reset value, ID version byte.
- Sub-module sample_narrow_axil_regs: AXI4-Lite handshake FSM and register file; top holds the 2-stage datapath.

## Test plan
- Defaults (IN_W 31, OUT_W 24, round-sat): s_data 64 → m_data 1; 256 → 2; MODE 00, 64 → 0.
- s_data 0x3FFF_FFFF round-sat → 0x7F_FFFF, CLIP_CNT 1; −2^30 → 0x80_0000, no clip.
- SHIFT=1, MODE 10, s_data 0x3FFF_FFFF → 0xFF_FFFF, CLIP_CNT unchanged; MODE 00 → 0x7F_FFFF, count +1.
- MUTE=0x2, four samples ch 0..3 value 256 → 2,0,2,2 with m_ch 0..3 in order.
- m_ready low 5 cycles during 8-sample burst → no loss/duplication, s_ready drops after 2 held samples, order preserved.
- Write 0x8 coincident with clip → reads 0; ID reads 0x1F18_0401; ARESETN pulse mid-burst → m_valid 0, CTRL reads 0x3.
